// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
package reaction_pkg;

    // Game sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_GO    = 3'd2,
        ST_DONE  = 3'd3,
        ST_FOUL  = 3'd4
    } state_t;

    // LFSR reset value; non-zero so the register never locks up
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed as a mask on bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Default width of millisecond counters and result registers
    localparam int unsigned DEFAULT_MS_W = 14;

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used to randomise the arming delay.
module reaction_lfsr
    import reaction_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] lfsr_q
);

    logic [15:0] lfsr_d;
    logic        feedback;

    // Next value: shift left, feed the XOR of the tapped bits into bit 0
    always_comb begin
        feedback = ^(lfsr_q & LFSR_TAPS);
        lfsr_d   = {lfsr_q[14:0], feedback};
    end

    // Shift every clock; async reset loads the non-zero seed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game sequencer: random arming delay, stimulus LED,
// millisecond response timing, false-start/timeout detection, best score.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11,
    parameter int unsigned TIMEOUT_MS   = 9999,
    parameter int unsigned MS_W         = DEFAULT_MS_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tick_1ms,
    input  logic            start_btn,
    input  logic            react_btn,
    output logic            led,
    output logic            count_en,
    output logic            bcd_stop,
    output logic            false_start,
    output logic            timeout,
    output logic            result_valid,
    output logic [MS_W-1:0] reaction_ms,
    output logic [MS_W-1:0] best_ms
);

    localparam logic [15:0]     RAND_MASK  = 16'((32'd1 << RAND_BITS) - 32'd1);
    localparam logic [MS_W-1:0] TIMEOUT_M1 = MS_W'(TIMEOUT_MS - 1);
    localparam logic [MS_W-1:0] TIMEOUT_V  = MS_W'(TIMEOUT_MS);

    state_t          state_q, state_d;
    logic            start_q, react_q;
    logic [MS_W-1:0] wait_q, wait_d;
    logic [MS_W-1:0] rt_q, rt_d;
    logic [MS_W-1:0] reaction_q, reaction_d;
    logic [MS_W-1:0] best_q, best_d;
    logic            timeout_q, timeout_d;
    logic            rv_q, rv_d;
    logic [15:0]     lfsr_q;
    logic            start_evt, react_evt;
    logic            arm;

    reaction_lfsr u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .lfsr_q (lfsr_q)
    );

    // Rising-edge events: current level against the one-clock-old level
    assign start_evt = start_btn & ~start_q;
    assign react_evt = react_btn & ~react_q;

    // Register button levels for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            react_q <= 1'b0;
        end else begin
            start_q <= start_btn;
            react_q <= react_btn;
        end
    end

    // Next-state, counter and score logic
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rt_d       = rt_q;
        reaction_d = reaction_q;
        best_d     = best_q;
        timeout_d  = timeout_q;
        rv_d       = 1'b0;
        arm        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_evt) arm = 1'b1;
            end
            ST_ARMED: begin
                // A premature press beats a same-cycle delay expiry
                if (react_evt) begin
                    state_d = ST_FOUL;
                end else if (tick_1ms) begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == MS_W'(1)) state_d = ST_GO;
                end
            end
            ST_GO: begin
                // A press wins over a same-cycle tick and over the timeout
                if (react_evt) begin
                    state_d    = ST_DONE;
                    reaction_d = rt_q;
                    rv_d       = 1'b1;
                end else if (tick_1ms) begin
                    if (rt_q == TIMEOUT_M1) begin
                        state_d    = ST_DONE;
                        reaction_d = TIMEOUT_V;
                        timeout_d  = 1'b1;
                        rv_d       = 1'b1;
                    end else begin
                        rt_d = rt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Score compare happens on the cycle after the result latches
                if (rv_q && !timeout_q && (reaction_q < best_q)) best_d = reaction_q;
                if (start_evt) arm = 1'b1;
            end
            ST_FOUL: begin
                if (start_evt) arm = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Common load for every new attempt
        if (arm) begin
            state_d   = ST_ARMED;
            wait_d    = MS_W'(32'(MIN_DELAY_MS) + 32'(lfsr_q & RAND_MASK));
            rt_d      = '0;
            timeout_d = 1'b0;
        end
    end

    // State, counters and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            rt_q       <= '0;
            reaction_q <= '0;
            best_q     <= '1;
            timeout_q  <= 1'b0;
            rv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rt_q       <= rt_d;
            reaction_q <= reaction_d;
            best_q     <= best_d;
            timeout_q  <= timeout_d;
            rv_q       <= rv_d;
        end
    end

    // Moore outputs decoded from the state register
    assign led          = (state_q == ST_GO);
    assign count_en     = led;
    assign bcd_stop     = (state_q == ST_DONE) || (state_q == ST_FOUL);
    assign false_start  = (state_q == ST_FOUL);
    assign timeout      = timeout_q;
    assign result_valid = rv_q;
    assign reaction_ms  = reaction_q;
    assign best_ms      = best_q;

endmodule
